fft16_stage_ctrl: RTL and testbench

Sequencer for the 16-point radix-2 FFT datapath (four butterfly stages, eight butterfly2 units, twiddle ROMs and the stage-input muxes).
- Accepts one input frame through a valid/ready handshake.
- Steps the shared datapath through STAGES passes by driving mux selects, per-butterfly twiddle indices and write-back strobes.
- Presents the result through an output valid/ready handshake.
- Sits beside the FFT top level and owns all of its control.

---
 rtl/fft16_pkg.sv | 24 ++
 rtl/fft16_stage_ctrl_if.sv | 24 ++
 rtl/fft16_tw_idx_gen.sv | 19 +
 rtl/fft16_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_fft16_stage_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fft16_pkg.sv
// Shared types, constants and twiddle-index helper for the 16-point radix-2 FFT control.
package fft16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FFT_N    = 16;
    localparam int unsigned NUM_BFLY = 8;
    localparam int unsigned TW_IDX_W = 3;
    localparam int unsigned STAGE_W  = 2;
    localparam int unsigned TW_BUS_W = NUM_BFLY * TW_IDX_W;

    // Butterfly b in stage s uses twiddle (b mod 2^s) scaled to the 8-entry ROM.
    function automatic logic [TW_IDX_W-1:0] tw_index(input logic [STAGE_W-1:0] stage,
                                                     input logic [TW_IDX_W-1:0] b);
        logic [TW_IDX_W-1:0] mask;
        mask = TW_IDX_W'((32'd1 << stage) - 32'd1);
        return TW_IDX_W'((b & mask) << (TW_IDX_W - 32'(stage)));
    endfunction

endpackage

// File: rtl/fft16_stage_ctrl_if.sv
// Handshake and datapath-control bundle between the FFT sequencer and its datapath.
interface fft16_stage_ctrl_if;
    import fft16_pkg::*;

    logic                i_in_valid;
    logic                o_in_ready;
    logic                o_load;
    logic [STAGE_W-1:0]  o_mux_sel;
    logic [TW_BUS_W-1:0] o_tw_idx;
    logic                o_wb_en;
    logic                o_out_valid;
    logic                i_out_ready;

    modport master (
        input  i_in_valid, i_out_ready,
        output o_in_ready, o_load, o_mux_sel, o_tw_idx, o_wb_en, o_out_valid
    );

    modport slave (
        output i_in_valid, i_out_ready,
        input  o_in_ready, o_load, o_mux_sel, o_tw_idx, o_wb_en, o_out_valid
    );

endinterface

// File: rtl/fft16_tw_idx_gen.sv
// Packs the eight per-butterfly twiddle indices for the current stage; zero when not running.
module fft16_tw_idx_gen
    import fft16_pkg::*;
(
    input  logic [STAGE_W-1:0]  i_stage,
    input  logic                i_run,
    output logic [TW_BUS_W-1:0] o_tw_idx
);

    always_comb begin
        o_tw_idx = '0;
        if (i_run) begin
            for (int unsigned b = 0; b < NUM_BFLY; b++) begin
                o_tw_idx[b*TW_IDX_W +: TW_IDX_W] = tw_index(i_stage, TW_IDX_W'(b));
            end
        end
    end

endmodule

// File: rtl/fft16_stage_ctrl.sv
// Sequencer for the 16-point FFT: accepts a frame, steps the shared butterflies through
// each stage with a fixed result latency, then holds the result until downstream takes it.
module fft16_stage_ctrl
    import fft16_pkg::*;
#(
    parameter int unsigned STAGES   = 4,
    parameter int unsigned BFLY_LAT = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fft16_stage_ctrl_if.master if_ctl,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_frame_cnt
);

    localparam int unsigned        LAT_W      = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(BFLY_LAT - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGES - 1);

    state_e              r_state;
    logic [STAGE_W-1:0]  r_stage;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [CNT_W-1:0]    r_frame_cnt;

    state_e              w_state_nxt;
    logic [STAGE_W-1:0]  w_stage_nxt;
    logic [LAT_W-1:0]    w_lat_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_lat_last;
    logic                w_run;
    logic [TW_BUS_W-1:0] w_tw_idx;

    assign w_lat_last = (r_lat_cnt == LAT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_stage     <= '0;
            r_lat_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage     <= w_stage_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_frame_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_lat_nxt   = r_lat_cnt;
        w_cnt_nxt   = r_frame_cnt;
        case (r_state)
            IDLE: begin
                if (if_ctl.i_in_valid) begin
                    w_state_nxt = RUN;
                    w_stage_nxt = '0;
                    w_lat_nxt   = '0;
                end
            end
            RUN: begin
                if (w_lat_last) begin
                    w_lat_nxt = '0;
                    if (r_stage == STAGE_LAST) begin
                        w_state_nxt = DONE;
                        w_stage_nxt = '0;
                    end else begin
                        w_stage_nxt = r_stage + STAGE_W'(1);
                    end
                end else begin
                    w_lat_nxt = r_lat_cnt + LAT_W'(1);
                end
            end
            DONE: begin
                if (if_ctl.i_out_ready) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = r_frame_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode the registered state but are forced low while reset is asserted.
    always_comb begin
        if_ctl.o_in_ready  = 1'b0;
        if_ctl.o_load      = 1'b0;
        if_ctl.o_mux_sel   = '0;
        if_ctl.o_wb_en     = 1'b0;
        if_ctl.o_out_valid = 1'b0;
        o_busy             = 1'b0;
        w_run              = 1'b0;
        if (!i_rst) begin
            case (r_state)
                IDLE: begin
                    if_ctl.o_in_ready = 1'b1;
                    if_ctl.o_load     = if_ctl.i_in_valid;
                end
                RUN: begin
                    if_ctl.o_mux_sel = r_stage;
                    if_ctl.o_wb_en   = w_lat_last;
                    o_busy           = 1'b1;
                    w_run            = 1'b1;
                end
                DONE: begin
                    if_ctl.o_out_valid = 1'b1;
                    o_busy             = 1'b1;
                end
                default: ;
            endcase
        end
    end

    fft16_tw_idx_gen u_tw_idx_gen (
        .i_stage  (r_stage),
        .i_run    (w_run),
        .o_tw_idx (w_tw_idx)
    );

    assign if_ctl.o_tw_idx = w_tw_idx;
    assign o_frame_cnt     = i_rst ? '0 : r_frame_cnt;

endmodule

// File: tb/tb_fft16_stage_ctrl.sv
// Randomized and directed bench for fft16_stage_ctrl against an elapsed-time reference model.
module tb_fft16_stage_ctrl;

    localparam int S = 4;
    localparam int L = 2;

    logic clk;
    logic rst_m;
    logic rst_s;
    logic busy_m, busy_1, busy_7;
    logic [7:0] cnt_m, cnt_1, cnt_7;

    fft16_stage_ctrl_if ifm ();
    fft16_stage_ctrl_if if1 ();
    fft16_stage_ctrl_if if7 ();

    fft16_stage_ctrl #(.STAGES(4), .BFLY_LAT(2), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst_m), .if_ctl(ifm), .o_busy(busy_m), .o_frame_cnt(cnt_m));
    fft16_stage_ctrl #(.STAGES(4), .BFLY_LAT(1), .CNT_W(8)) u_dut_l1 (
        .i_clk(clk), .i_rst(rst_s), .if_ctl(if1), .o_busy(busy_1), .o_frame_cnt(cnt_1));
    fft16_stage_ctrl #(.STAGES(4), .BFLY_LAT(7), .CNT_W(8)) u_dut_l7 (
        .i_clk(clk), .i_rst(rst_s), .if_ctl(if7), .o_busy(busy_7), .o_frame_cnt(cnt_7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles elapsed since the frame was accepted.
    int m_ph  = 0;   // 0 idle, 1 running, 2 result held
    int m_k   = 0;
    int m_cnt = 0;
    int cyc   = 0;
    bit b2b_mode = 0;
    int last_load = -1;

    function automatic logic [23:0] tw_ref(input int s);
        logic [23:0] t;
        t = '0;
        for (int b = 0; b < 8; b++) t[3*b +: 3] = 3'((b % (1 << s)) << (3 - s));
        return t;
    endfunction

    task automatic model_check();
        logic e_rdy, e_load, e_wb, e_ov, e_busy;
        logic [1:0]  e_mux;
        logic [23:0] e_tw;
        int st;
        e_rdy = 0; e_load = 0; e_wb = 0; e_ov = 0; e_busy = 0; e_mux = '0; e_tw = '0;
        if (!rst_m) begin
            if (m_ph == 0) begin
                e_rdy  = 1;
                e_load = ifm.i_in_valid;
            end else if (m_ph == 1) begin
                st     = m_k / L;
                e_mux  = 2'(st);
                e_tw   = tw_ref(st);
                e_wb   = ((m_k % L) == L - 1);
                e_busy = 1;
            end else begin
                e_ov   = 1;
                e_busy = 1;
            end
        end
        check_eq("in_ready",  32'(ifm.o_in_ready),  32'(e_rdy));
        check_eq("load",      32'(ifm.o_load),      32'(e_load));
        check_eq("mux_sel",   32'(ifm.o_mux_sel),   32'(e_mux));
        check_eq("tw_idx",    32'(ifm.o_tw_idx),    32'(e_tw));
        check_eq("wb_en",     32'(ifm.o_wb_en),     32'(e_wb));
        check_eq("out_valid", 32'(ifm.o_out_valid), 32'(e_ov));
        check_eq("busy",      32'(busy_m),          32'(e_busy));
        check_eq("frame_cnt", 32'(cnt_m),           rst_m ? 32'd0 : 32'(m_cnt));
        if (b2b_mode && ifm.o_load) begin
            if (last_load >= 0) check_eq("accept_interval", 32'(cyc - last_load), 32'd10);
            last_load = cyc;
        end
    endtask

    task automatic model_update(input bit v, input bit r, input bit rst);
        if (rst) begin
            m_ph = 0; m_cnt = 0;
        end else if (m_ph == 0) begin
            if (v) begin m_ph = 1; m_k = 0; end
        end else if (m_ph == 1) begin
            m_k++;
            if (m_k == S * L) m_ph = 2;
        end else if (r) begin
            m_ph = 0;
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic cycle(input bit v, input bit r, input bit rst);
        @(negedge clk);
        ifm.i_in_valid  = v;
        ifm.i_out_ready = r;
        rst_m           = rst;
        #1;
        model_check();
        @(posedge clk);
        model_update(v, r, rst);
        cyc++;
    endtask

    // Parameter sweep on BFLY_LAT=1 and BFLY_LAT=7 instances, frames back to back.
    bit sweep_done = 0;
    initial begin
        int t_load[2];
        int wbn[2];
        int frames[2];
        bit armed[2];
        bit lv, wb, ov;
        int scyc;
        rst_s = 1'b1;
        if1.i_in_valid = 0; if1.i_out_ready = 0;
        if7.i_in_valid = 0; if7.i_out_ready = 0;
        for (int i = 0; i < 2; i++) begin t_load[i] = 0; wbn[i] = 0; frames[i] = 0; armed[i] = 0; end
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        if1.i_in_valid = 1; if1.i_out_ready = 1;
        if7.i_in_valid = 1; if7.i_out_ready = 1;
        scyc = 0;
        repeat (200) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                lv = (i == 0) ? if1.o_load      : if7.o_load;
                wb = (i == 0) ? if1.o_wb_en     : if7.o_wb_en;
                ov = (i == 0) ? if1.o_out_valid : if7.o_out_valid;
                if (lv) begin
                    if (frames[i] > 0) check_eq("sweep_interval", 32'(scyc - t_load[i]),
                                                (i == 0) ? 32'd6 : 32'd30);
                    t_load[i] = scyc; wbn[i] = 0; armed[i] = 1;
                end
                if (wb) wbn[i]++;
                if (ov && armed[i]) begin
                    check_eq("sweep_latency", 32'(scyc - t_load[i]), (i == 0) ? 32'd5 : 32'd29);
                    check_eq("sweep_wb_count", 32'(wbn[i]), 32'd4);
                    armed[i] = 0;
                    frames[i]++;
                end
            end
            scyc++;
        end
        check_eq("sweep_frames_l1", 32'(frames[0] >= 20), 32'd1);
        check_eq("sweep_frames_l7", 32'(frames[1] >= 5), 32'd1);
        sweep_done = 1;
    end

    initial begin
        bit saw_wrap;
        logic [7:0] prev_cnt;
        rst_m = 1'b1;
        ifm.i_in_valid = 0;
        ifm.i_out_ready = 0;

        // Reset, with stray inputs that must not leak through.
        cycle(1, 1, 1);
        cycle(0, 0, 1);

        // Single frame; ready held early has no effect before the result.
        cycle(1, 0, 0);
        repeat (9) cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Backpressure in DONE with a competing input frame.
        cycle(1, 0, 0);
        repeat (8) cycle(0, 0, 0);
        repeat (5) cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        repeat (8) cycle(0, 0, 0);
        cycle(0, 1, 0);

        // Reset during stage 2, then a normal frame.
        cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        cycle(1, 1, 1);
        cycle(0, 0, 0);
        cycle(1, 1, 0);
        repeat (10) cycle(0, 1, 0);

        // Back-to-back through a counter wrap.
        b2b_mode = 1;
        last_load = -1;
        saw_wrap = 0;
        prev_cnt = cnt_m;
        repeat (3005) begin
            cycle(1, 1, 0);
            if (prev_cnt == 8'd255 && cnt_m == 8'd0) saw_wrap = 1;
            prev_cnt = cnt_m;
        end
        b2b_mode = 0;
        check_eq("cnt_wrap_seen", 32'(saw_wrap), 32'd1);

        // Random traffic with occasional reset.
        repeat (2000) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 63) == 0));

        wait (sweep_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
